// File: rtl/div_pkg.sv
// Shared types and constants for the multicycle signed divider.
package div_pkg;

  localparam int unsigned DIV_W = 32;
  localparam int unsigned CNT_W = $clog2(DIV_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    ZERO = 2'd3
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift {rem, quo} left, trial-subtract, restore on borrow.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Extra top bit keeps the borrow visible even when shifted remainder reaches 2^WIDTH-1.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, dvs};
    rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
  end

endmodule

// File: rtl/div_unit.sv
// Multicycle signed divider: magnitudes divided by div_step, signs restored in FIX.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividendo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic             sign_dvd;
  logic             sign_dvs;

  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  logic load;
  logic step;
  logic fix;
  logic busy_next;
  logic done_next;
  logic div_zero_next;

  // Two's-complement magnitude; the most negative value maps onto itself as unsigned.
  always_comb begin
    dvd_abs = dividendo[WIDTH-1] ? -dividendo : dividendo;
    dvs_abs = divisor[WIDTH-1]   ? -divisor   : divisor;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .dvs      (dvs_reg),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = (divisor != '0) ? CALC : ZERO;
      end
      CALC: begin
        if (cnt == '0) state_next = FIX;
      end
      FIX:     state_next = IDLE;
      ZERO:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load          = 1'b0;
    step          = 1'b0;
    fix           = 1'b0;
    done_next     = 1'b0;
    div_zero_next = 1'b0;
    busy_next     = (state_next != IDLE);
    case (state)
      IDLE: load = start && (divisor != '0);
      CALC: step = 1'b1;
      FIX: begin
        fix       = 1'b1;
        done_next = 1'b1;
      end
      ZERO: begin
        done_next     = 1'b1;
        div_zero_next = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      rem_reg  <= '0;
      quo_reg  <= '0;
      dvs_reg  <= '0;
      sign_dvd <= 1'b0;
      sign_dvs <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      busy     <= busy_next;
      done     <= done_next;
      div_zero <= div_zero_next;
      if (load) begin
        rem_reg  <= '0;
        quo_reg  <= dvd_abs;
        dvs_reg  <= dvs_abs;
        sign_dvd <= dividendo[WIDTH-1];
        sign_dvs <= divisor[WIDTH-1];
        cnt      <= CW'(WIDTH - 1);
      end else if (step) begin
        rem_reg <= rem_step;
        quo_reg <= quo_step;
        cnt     <= cnt - CW'(1);
      end
      if (fix) begin
        lo <= (sign_dvd ^ sign_dvs) ? -quo_reg : quo_reg;
        hi <= sign_dvd ? -rem_reg : rem_reg;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases, divide-by-zero, ignored start, reset abort, random.
module tb_div_unit;

  localparam int unsigned W       = 32;
  localparam int          LAT_DIV = W + 1;
  localparam int          LAT_ZER = 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  dividendo = '0;
  logic [W-1:0]  divisor = '0;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          busy;
  logic          done;
  logic          div_zero;

  int checks = 0;
  int fails  = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  div_unit #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .dividendo (dividendo),
    .divisor   (divisor),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: signed division in 64-bit arithmetic, truncating toward zero.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb, lq, lr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lq = sa / sb;
    lr = sa % sb;
    q  = 32'(lq);
    r  = 32'(lr);
  endfunction

  // Issue one operation; returns edges from acceptance to done and whether busy behaved.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke,
                         output int lat, output bit busy_ok);
    busy_ok   = 1'b1;
    lat       = 0;
    start     = 1'b1;
    dividendo = a;
    divisor   = b;
    @(posedge clock); #1;
    start     = 1'b0;
    dividendo = $urandom;
    divisor   = $urandom;
    if (busy !== 1'b1) busy_ok = 1'b0;
    while (lat < 100) begin
      if (poke && (lat == 4 || lat == 19)) begin
        start     = 1'b1;
        dividendo = 32'd55;
        divisor   = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      lat++;
      if (done) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    start = 1'b0;
    if (busy !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (hi !== '0)       begin fails++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== '0)       begin fails++; $display("FAIL reset_lo got=%h exp=0", lo); end
    checks++; if (busy !== 1'b0)   begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)   begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (div_zero !== 1'b0) begin fails++; $display("FAIL reset_div_zero got=%b exp=0", div_zero); end
    reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[6] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'h8000_0000, 32'd5, 32'd100};
    logic [W-1:0] tb[6] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd9, 32'd7};
    logic [W-1:0] tl[6] = '{32'd14, 32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'h8000_0000, 32'd0, 32'd14};
    logic [W-1:0] th[6] = '{32'd2, 32'hFFFF_FFFE, 32'd2, 32'd0, 32'd5, 32'd2};
    int lat;
    bit bok;
    for (int i = 0; i < 6; i++) begin
      run_div(ta[i], tb[i], 1'b0, lat, bok);
      exp_lo = tl[i];
      exp_hi = th[i];
      checks++; if (lat !== LAT_DIV) begin fails++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, LAT_DIV); end
      checks++; if (lo !== exp_lo)   begin fails++; $display("FAIL dir%0d_lo got=%h exp=%h", i, lo, exp_lo); end
      checks++; if (hi !== exp_hi)   begin fails++; $display("FAIL dir%0d_hi got=%h exp=%h", i, hi, exp_hi); end
      checks++; if (div_zero !== 1'b0) begin fails++; $display("FAIL dir%0d_div_zero got=%b exp=0", i, div_zero); end
      checks++; if (bok !== 1'b1)    begin fails++; $display("FAIL dir%0d_busy got=%b exp=1", i, bok); end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    bit bok;
    run_div(32'd7, 32'd0, 1'b0, lat, bok);
    checks++; if (lat !== LAT_ZER)   begin fails++; $display("FAIL zero_latency got=%0d exp=%0d", lat, LAT_ZER); end
    checks++; if (div_zero !== 1'b1) begin fails++; $display("FAIL zero_flag got=%b exp=1", div_zero); end
    checks++; if (lo !== 32'd14)     begin fails++; $display("FAIL zero_lo_kept got=%h exp=%h", lo, 32'd14); end
    checks++; if (hi !== 32'd2)      begin fails++; $display("FAIL zero_hi_kept got=%h exp=%h", hi, 32'd2); end
    checks++; if (bok !== 1'b1)      begin fails++; $display("FAIL zero_busy got=%b exp=1", bok); end
    @(posedge clock); #1;
    checks++; if ({done, div_zero} !== 2'b00) begin fails++; $display("FAIL zero_pulse_width got=%b exp=00", {done, div_zero}); end
  endtask

  task automatic test_ignored_start();
    int lat;
    int extra;
    bit bok;
    run_div(32'd100, 32'd7, 1'b1, lat, bok);
    checks++; if (lat !== LAT_DIV) begin fails++; $display("FAIL ign_latency got=%0d exp=%0d", lat, LAT_DIV); end
    checks++; if (lo !== 32'd14)   begin fails++; $display("FAIL ign_lo got=%h exp=%h", lo, 32'd14); end
    checks++; if (hi !== 32'd2)    begin fails++; $display("FAIL ign_hi got=%h exp=%h", hi, 32'd2); end
    extra = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) extra++;
    end
    checks++; if (extra !== 0) begin fails++; $display("FAIL ign_extra_done got=%0d exp=0", extra); end
    exp_lo = 32'd14;
    exp_hi = 32'd2;
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    bit bok;
    start     = 1'b1;
    dividendo = 32'd100;
    divisor   = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    seen  = 0;
    repeat (10) begin
      @(posedge clock); #1;
      if (done) seen++;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++; if ({busy, done, div_zero} !== 3'b000) begin fails++; $display("FAIL rst_mid_flags got=%b exp=000", {busy, done, div_zero}); end
    checks++; if (hi !== '0) begin fails++; $display("FAIL rst_mid_hi got=%h exp=0", hi); end
    checks++; if (lo !== '0) begin fails++; $display("FAIL rst_mid_lo got=%h exp=0", lo); end
    repeat (40) begin
      @(posedge clock); #1;
      if (done || busy) seen++;
    end
    checks++; if (seen !== 0) begin fails++; $display("FAIL rst_mid_activity got=%0d exp=0", seen); end
    run_div(32'd9, 32'd3, 1'b0, lat, bok);
    exp_lo = 32'd3;
    exp_hi = 32'd0;
    checks++; if (lat !== LAT_DIV) begin fails++; $display("FAIL after_rst_latency got=%0d exp=%0d", lat, LAT_DIV); end
    checks++; if (lo !== exp_lo)   begin fails++; $display("FAIL after_rst_lo got=%h exp=%h", lo, exp_lo); end
    checks++; if (hi !== exp_hi)   begin fails++; $display("FAIL after_rst_hi got=%h exp=%h", hi, exp_hi); end
  endtask

  // Back-to-back random operations, each started in the cycle the previous done is visible.
  task automatic test_back_to_back();
    logic [W-1:0] a, b, q, r;
    int lat;
    int mode;
    int exp_lat;
    bit bok;
    for (int i = 0; i < 60; i++) begin
      a    = $urandom;
      mode = int'($urandom_range(0, 9));
      if (mode == 0)      b = '0;
      else if (mode < 5)  b = $urandom;
      else begin
        b = 32'($urandom_range(1, 20));
        if (mode > 7) b = -b;
        if (mode == 9) a = 32'($urandom_range(0, 40));
      end
      if (b != '0) begin
        ref_div(a, b, q, r);
        exp_lo  = q;
        exp_hi  = r;
        exp_lat = LAT_DIV;
      end else begin
        exp_lat = LAT_ZER;
      end
      run_div(a, b, 1'b0, lat, bok);
      checks++; if (lat !== exp_lat) begin fails++; $display("FAIL rnd%0d_latency a=%h b=%h got=%0d exp=%0d", i, a, b, lat, exp_lat); end
      checks++; if (lo !== exp_lo)   begin fails++; $display("FAIL rnd%0d_lo a=%h b=%h got=%h exp=%h", i, a, b, lo, exp_lo); end
      checks++; if (hi !== exp_hi)   begin fails++; $display("FAIL rnd%0d_hi a=%h b=%h got=%h exp=%h", i, a, b, hi, exp_hi); end
      checks++; if (div_zero !== (b == '0)) begin fails++; $display("FAIL rnd%0d_div_zero got=%b exp=%b", i, div_zero, (b == '0)); end
      checks++; if (bok !== 1'b1)    begin fails++; $display("FAIL rnd%0d_busy got=%b exp=1", i, bok); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
